k7_tape_decoder: RTL and testbench

K7_TAPE_DECODER -- requirements
Module: k7_tape_decoder

---
 rtl/k7_tape_decoder.sv | 180 ++++++++++++++++++
 tb/tb_k7_tape_decoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k7_tape_decoder.sv
// k7_tape_decoder: cassette-tape bit/byte decoder.
// A rising edge of the synchronised tape input ends one period. The period
// length is measured in clk_sys cycles and decides the bit: short periods are
// 1, long periods are 0. Bits are framed as start(0), 8 data bits LSB first,
// a parity bit and a stop bit(1). Completed bytes go out through a
// valid/ready holding register.
// Optional build macro: K7_PARITY_CHECK_EN. When it is defined, odd parity
// over data+parity is enforced and a frame that fails the check is dropped
// with a frame_err pulse.
module k7_tape_decoder #(
  parameter int GLITCH_MIN = 2000,
  parameter int SPLIT      = 14000,
  parameter int LONG_MAX   = 30000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       k7_tapein,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       overrun,
  output logic       frame_err,
  output logic       carrier
);

  localparam logic [15:0] GLITCH_V = 16'(GLITCH_MIN);
  localparam logic [15:0] SPLIT_V  = 16'(SPLIT);
  localparam logic [15:0] LONG_V   = 16'(LONG_MAX);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic        sync_dly_q, sync_dly_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
`ifdef K7_PARITY_CHECK_EN
  logic        par_q, par_d;
`endif
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        carrier_q, carrier_d;

  logic rise, accept, lost, bit_vld, bit_one;
  logic byte_done, frame_bad, consume;

  // Edge detection, period counter and period classification.
  always_comb begin
    sync_d     = {sync_q[0], k7_tapein};
    sync_dly_d = sync_q[1];
    rise       = sync_q[1] & ~sync_dly_q;
    // Edges arriving before GLITCH_MIN are spikes: the period keeps running.
    accept     = rise & (cnt_q >= GLITCH_V);
    // A saturated counter is also above LONG_MAX, so it counts as carrier loss.
    lost       = (cnt_q > LONG_V);
    bit_vld    = accept & ~lost;
    bit_one    = (cnt_q <= SPLIT_V);
    if (accept)
      cnt_d = 16'd1;
    else if (cnt_q == 16'hFFFF)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 16'd1;
    if (lost)
      carrier_d = 1'b0;
    else if (bit_vld)
      carrier_d = 1'b1;
    else
      carrier_d = carrier_q;
  end

  // Frame FSM next state plus the output holding register and handshake.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
`ifdef K7_PARITY_CHECK_EN
    par_d     = par_q;
`endif
    byte_done = 1'b0;
    frame_bad = 1'b0;
    if (lost) begin
      // Carrier loss drops any partial byte.
      state_d = S_IDLE;
    end else if (bit_vld) begin
      case (state_q)
        S_IDLE: begin
          if (!bit_one) begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end
        end
        S_DATA: begin
          shift_d = {bit_one, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7)
            state_d = S_PARITY;
        end
        S_PARITY: begin
`ifdef K7_PARITY_CHECK_EN
          par_d = bit_one;
`endif
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!bit_one)
            frame_bad = 1'b1;
`ifdef K7_PARITY_CHECK_EN
          else if (!(^{shift_q, par_q}))
            frame_bad = 1'b1;
`endif
          else
            byte_done = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    consume     = valid_q & data_ready;
    data_d      = data_q;
    valid_d     = valid_q & ~consume;
    overrun_d   = 1'b0;
    frame_err_d = frame_bad;
    if (byte_done) begin
      // The holding register accepts a new byte if it is empty or drains this cycle.
      if (!valid_q || consume) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= 2'b00;
      sync_dly_q  <= 1'b0;
      cnt_q       <= 16'd0;
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
`ifdef K7_PARITY_CHECK_EN
      par_q       <= 1'b0;
`endif
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      carrier_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      sync_dly_q  <= sync_dly_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
`ifdef K7_PARITY_CHECK_EN
      par_q       <= par_d;
`endif
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      carrier_q   <= carrier_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign carrier    = carrier_q;

endmodule

// File: tb/tb_k7_tape_decoder.sv
// Testbench for k7_tape_decoder with the period thresholds scaled down by 100
// (20 / 140 / 300) so that whole frames fit in a short run.
module tb_k7_tape_decoder;

  localparam int GMIN = 20;
  localparam int SPL  = 140;
  localparam int LMAX = 300;
`ifdef K7_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tapein;
  logic       ready;
  logic [7:0] data;
  logic       data_valid, overrun, frame_err, carrier;

  int n_cmp = 0;
  int n_bad = 0;
  int ov_cnt = 0;
  int fe_cnt = 0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  k7_tape_decoder #(.GLITCH_MIN(GMIN), .SPLIT(SPL), .LONG_MAX(LMAX)) dut (
    .clk_sys(clk), .reset_n(reset_n), .k7_tapein(tapein), .data(data),
    .data_valid(data_valid), .data_ready(ready), .overrun(overrun),
    .frame_err(frame_err), .carrier(carrier)
  );

  // Pulse counters and a log of every byte handed over (valid & ready).
  always @(negedge clk) begin
    if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (data_valid === 1'b1 && ready === 1'b1) got_q.push_back(data);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (all start and end at posedge+1) -------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_period(input int p, input bit spike);
    tapein = 1'b1;
    repeat (2) @(posedge clk);
    #1 tapein = 1'b0;
    if (spike) begin
      repeat (3) @(posedge clk);
      #1 tapein = 1'b1;
      repeat (2) @(posedge clk);
      #1 tapein = 1'b0;
      repeat (p - 7) @(posedge clk);
    end else begin
      repeat (p - 2) @(posedge clk);
    end
    #1;
  endtask

  // Rising edge that terminates the previous period; returns in the edge-detect cycle.
  task automatic close_edge();
    tapein = 1'b1;
    repeat (2) @(posedge clk);
    #1 tapein = 1'b0;
  endtask

  function automatic int pick_period(input bit v, input bit rnd);
    int r;
    if (!rnd) return v ? 100 : 200;
    r = int'($urandom % 4);
    if (v) begin
      if (r == 0) return GMIN;
      if (r == 1) return SPL;
      return int'($urandom_range(SPL, GMIN));
    end
    if (r == 0) return SPL + 1;
    if (r == 1) return LMAX;
    return int'($urandom_range(LMAX, SPL + 1));
  endfunction

  task automatic send_bit(input bit v, input bit rnd, input bit spike);
    send_period(pick_period(v, rnd), spike);
  endtask

  task automatic send_leader(input int n, input int p);
    for (int i = 0; i < n; i++) send_period(p, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par, input bit stp,
                            input bit rnd, input bit spike);
    send_bit(1'b0, rnd, spike);
    for (int i = 0; i < 8; i++) send_bit(b[i], rnd, spike);
    send_bit(par, rnd, spike);
    send_bit(stp, rnd, spike);
  endtask

  task automatic consume();
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    tapein  = 1'b0;
    ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 tapein = 1'b1;
    repeat (3) @(posedge clk);
    #1 tapein = 1'b0;
    @(negedge clk);
    n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", data); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_cmp++; if (carrier !== 1'b0) begin n_bad++; $display("FAIL reset_carrier: got %b expected 0", carrier); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(400);
  endtask

  task automatic test_basic();
    int fe0;
    fe0 = fe_cnt;
    ready = 1'b0;
    send_leader(20, 100);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    close_edge();
    @(negedge clk);
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL basic_latency_early: valid %b expected 0", data_valid); end
    @(negedge clk);
    n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b expected 1", data_valid); end
    n_cmp++; if (data !== 8'hA5) begin n_bad++; $display("FAIL basic_data: got %h expected a5", data); end
    n_cmp++; if (carrier !== 1'b1) begin n_bad++; $display("FAIL basic_carrier: got %b expected 1", carrier); end
    @(posedge clk);
    #1;
    idle(3);
    n_cmp++; if (fe_cnt !== fe0) begin n_bad++; $display("FAIL basic_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
    consume();
    @(negedge clk);
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL basic_consume: valid %b expected 0", data_valid); end
    @(posedge clk);
    #1;
    idle(400);
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt;
    ready = 1'b0;
    send_leader(4, 100);
    send_frame(8'h12, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b1, 1'b0, 1'b0);
    close_edge();
    idle(4);
    n_cmp++; if (data !== 8'h12) begin n_bad++; $display("FAIL overrun_data: got %h expected 12", data); end
    n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL overrun_valid: got %b expected 1", data_valid); end
    n_cmp++; if (ov_cnt - ov0 !== 1) begin n_bad++; $display("FAIL overrun_pulses: got %0d expected 1", ov_cnt - ov0); end
    consume();
    idle(400);
  endtask

  task automatic test_back_to_back();
    int ov0;
    ov0 = ov_cnt;
    ready = 1'b0;
    send_leader(4, 100);
    send_frame(8'h12, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h34, 1'b0, 1'b1, 1'b0, 1'b0);
    close_edge();
    ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (data_valid !== 1'b1 || data !== 8'h12) begin n_bad++; $display("FAIL b2b_first: valid %b data %h expected 1/12", data_valid, data); end
    @(posedge clk);
    #1 ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid_held: got %b expected 1", data_valid); end
    n_cmp++; if (data !== 8'h34) begin n_bad++; $display("FAIL b2b_data: got %h expected 34", data); end
    @(posedge clk);
    #1;
    idle(3);
    n_cmp++; if (ov_cnt !== ov0) begin n_bad++; $display("FAIL b2b_overrun: got %0d pulses expected 0", ov_cnt - ov0); end
    consume();
    idle(400);
  endtask

  task automatic test_parity();
    int fe0;
    fe0 = fe_cnt;
    ready = 1'b0;
    send_leader(4, 100);
    send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    close_edge();
    idle(4);
`ifdef K7_PARITY_CHECK_EN
    n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL parity_frame_err: got %0d pulses expected 1", fe_cnt - fe0); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL parity_valid: got %b expected 0", data_valid); end
`else
    n_cmp++; if (fe_cnt !== fe0) begin n_bad++; $display("FAIL parity_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
    n_cmp++; if (data_valid !== 1'b1 || data !== 8'h00) begin n_bad++; $display("FAIL parity_data: valid %b data %h expected 1/00", data_valid, data); end
`endif
    consume();
    idle(400);
  endtask

  task automatic test_carrier();
    int base;
    base = got_q.size();
    ready = 1'b1;
    send_leader(4, 100);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1);
    close_edge();
    idle(5);
    n_cmp++; if (got_q.size() !== base + 1) begin n_bad++; $display("FAIL spike_count: got %0d bytes expected 1", got_q.size() - base); end
    else begin
      n_cmp++; if (got_q[base] !== 8'hC3) begin n_bad++; $display("FAIL spike_data: got %h expected c3", got_q[base]); end
    end
    idle(400);
    send_leader(4, 100);
    n_cmp++; if (carrier !== 1'b1) begin n_bad++; $display("FAIL carrier_on: got %b expected 1", carrier); end
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(i[0], 1'b0, 1'b0);
    idle(400);
    n_cmp++; if (carrier !== 1'b0) begin n_bad++; $display("FAIL carrier_loss: got %b expected 0", carrier); end
    n_cmp++; if (got_q.size() !== base + 1) begin n_bad++; $display("FAIL loss_no_byte: got %0d bytes expected 1", got_q.size() - base); end
    send_leader(4, 100);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    close_edge();
    idle(5);
    n_cmp++; if (got_q.size() !== base + 2) begin n_bad++; $display("FAIL loss_resume_count: got %0d bytes expected 2", got_q.size() - base); end
    else begin
      n_cmp++; if (got_q[base + 1] !== 8'h3C) begin n_bad++; $display("FAIL loss_resume_data: got %h expected 3c", got_q[base + 1]); end
    end
    ready = 1'b0;
    idle(400);
  endtask

  task automatic test_reset_midbyte();
    int base;
    base = got_q.size();
    ready = 1'b1;
    send_leader(4, 100);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0, 1'b0);
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (data_valid !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("FAIL midreset_flags: valid %b ovr %b ferr %b expected 0", data_valid, overrun, frame_err); end
    n_cmp++; if (carrier !== 1'b0) begin n_bad++; $display("FAIL midreset_carrier: got %b expected 0", carrier); end
    n_cmp++; if (data !== 8'h00) begin n_bad++; $display("FAIL midreset_data: got %h expected 00", data); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(3);
    send_leader(4, 100);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    close_edge();
    idle(5);
    n_cmp++; if (got_q.size() !== base + 1) begin n_bad++; $display("FAIL midreset_count: got %0d bytes expected 1", got_q.size() - base); end
    else begin
      n_cmp++; if (got_q[base] !== 8'h5A) begin n_bad++; $display("FAIL midreset_byte: got %h expected 5a", got_q[base]); end
    end
    ready = 1'b0;
    idle(400);
  endtask

  task automatic test_random();
    int base, fe0, ov0, exp_fe;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    bit par, stp, ok;
    base = got_q.size();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    exp_fe = 0;
    ready = 1'b1;
    for (int f = 0; f < 10; f++) begin
      b   = 8'($urandom);
      par = ~(^b);
      if ($urandom % 4 == 0) par = ~par;
      stp = ($urandom % 6 != 0);
      // Reference: a frame is delivered only with a good stop bit and,
      // when checking is on, an odd number of ones in data+parity.
      ok = stp && (!PCHK || ((($countones(b) + int'(par)) % 2) == 1));
      if (ok) exp_q.push_back(b);
      else exp_fe++;
      for (int l = 0; l < 1 + int'($urandom % 3); l++) send_bit(1'b1, 1'b1, 1'($urandom % 2));
      send_frame(b, par, stp, 1'b1, 1'($urandom % 2));
    end
    close_edge();
    idle(5);
    n_cmp++; if (got_q.size() - base !== exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d bytes expected %0d", got_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) begin
        n_cmp++; if (got_q[base + i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_byte%0d: got %h expected %h", i, got_q[base + i], exp_q[i]); end
      end
    end
    n_cmp++; if (fe_cnt - fe0 !== exp_fe) begin n_bad++; $display("FAIL rand_frame_err: got %0d pulses expected %0d", fe_cnt - fe0, exp_fe); end
    n_cmp++; if (ov_cnt !== ov0) begin n_bad++; $display("FAIL rand_overrun: got %0d pulses expected 0", ov_cnt - ov0); end
    ready = 1'b0;
    idle(400);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_parity();
    test_carrier();
    test_reset_midbyte();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
